zion_riscv_bj_redirect: RTL and testbench

//  Consumes branch/jump execution results (taken flags, target address, link PC) one stage downstream of BJ execute.

---
 rtl/zion_riscv_bj_pkg.sv | 25 ++
 rtl/zion_riscv_bj_mispred_chk.sv | 35 +++
 rtl/zion_riscv_bj_redirect.sv | 168 ++++++++++++++++
 tb/tb_zion_riscv_bj_redirect.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/zion_riscv_bj_pkg.sv
// Shared types and constants for the branch/jump redirect block.
// XLEN follows RV64; alignment masks select 2- or 4-byte target alignment.
package zion_riscv_bj_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REDIR = 2'd1,
    FLUSH = 2'd2
  } bj_state_e;

  localparam int unsigned CNT_W = 4;

  // Bits of the target that must be zero for a legal fetch address
  localparam logic [1:0] ALIGN_MASK_RVC = 2'b01;
  localparam logic [1:0] ALIGN_MASK_STD = 2'b11;

  function automatic int unsigned xlen_f(input int unsigned rv64);
    return (rv64 != 0) ? 64 : 32;
  endfunction

  function automatic logic [1:0] align_mask_f(input int unsigned rvc);
    return (rvc != 0) ? ALIGN_MASK_RVC : ALIGN_MASK_STD;
  endfunction

endpackage

// File: rtl/zion_riscv_bj_mispred_chk.sv
// Combinational resolution of a BJ result against the fetch prediction:
// taken, misaligned target, mispredict and the corrected fetch target.
module zion_riscv_bj_mispred_chk
  import zion_riscv_bj_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RVC  = 0
) (
  input  logic [1:0]      bj_en_i,
  input  logic            pred_taken_i,
  input  logic [XLEN-1:0] tgt_addr_i,
  input  logic [XLEN-1:0] pred_tgt_i,
  input  logic [XLEN-1:0] link_pc_i,
  output logic            taken_o,
  output logic            misalign_o,
  output logic            mispred_o,
  output logic [XLEN-1:0] target_o
);

  localparam logic [1:0] ALIGN_MASK = align_mask_f(RVC);

  logic taken;
  logic dir_wrong;
  logic tgt_wrong;

  assign taken      = |bj_en_i;
  assign misalign_o = taken & (|(tgt_addr_i[1:0] & ALIGN_MASK));
  assign dir_wrong  = taken ^ pred_taken_i;
  // Target only matters when the branch actually goes somewhere
  assign tgt_wrong  = taken & (tgt_addr_i != pred_tgt_i);
  assign mispred_o  = dir_wrong | tgt_wrong;
  assign target_o   = taken ? tgt_addr_i : link_pc_i;
  assign taken_o    = taken;

endmodule

// File: rtl/zion_riscv_bj_redirect.sv
// BJ result checker one stage after execute: redirect/flush FSM, link-PC
// writeback and misaligned-target exception, all registered.
//   state | meaning
//   IDLE  | accepting EX results
//   REDIR | holding redirect PC until fetch accepts, flushing
//   FLUSH | flushing younger stages for FLUSH_CYC cycles
module zion_riscv_bj_redirect
  import zion_riscv_bj_pkg::*;
#(
  parameter  int unsigned RV64      = 0,
  parameter  int unsigned RVC       = 0,
  parameter  int unsigned FLUSH_CYC = 2,
  localparam int unsigned XLEN      = xlen_f(RV64)
) (
  input  logic            iClk,
  input  logic            iRst_n,
  input  logic            iExVld,
  output logic            oExRdy,
  input  logic [1:0]      iBjEn,
  input  logic            iJump,
  input  logic [XLEN-1:0] iTgtAddr,
  input  logic [XLEN-1:0] iLinkPc,
  input  logic [4:0]      iRdIdx,
  input  logic            iPredTaken,
  input  logic [XLEN-1:0] iPredTgt,
  input  logic            iKill,
  output logic            oRedirVld,
  input  logic            iRedirRdy,
  output logic [XLEN-1:0] oRedirPc,
  output logic            oFlush,
  output logic            oWbVld,
  output logic [4:0]      oWbIdx,
  output logic [XLEN-1:0] oWbData,
  output logic            oExcVld,
  output logic [XLEN-1:0] oExcTval
);

  localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_CYC);

  bj_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  redir_pc_q, redir_pc_d;
  logic             wb_vld_q, wb_vld_d;
  logic [4:0]       wb_idx_q, wb_idx_d;
  logic [XLEN-1:0]  wb_data_q, wb_data_d;
  logic             exc_vld_q, exc_vld_d;
  logic [XLEN-1:0]  exc_tval_q, exc_tval_d;

  logic             ex_acc;
  logic             chk_taken;
  logic             chk_misalign;
  logic             chk_mispred;
  logic [XLEN-1:0]  chk_target;
  logic             link_wr;

  zion_riscv_bj_mispred_chk #(
    .XLEN (XLEN),
    .RVC  (RVC)
  ) u_mispred_chk (
    .bj_en_i      (iBjEn),
    .pred_taken_i (iPredTaken),
    .tgt_addr_i   (iTgtAddr),
    .pred_tgt_i   (iPredTgt),
    .link_pc_i    (iLinkPc),
    .taken_o      (chk_taken),
    .misalign_o   (chk_misalign),
    .mispred_o    (chk_mispred),
    .target_o     (chk_target)
  );

  assign oExRdy  = (state_q == IDLE) & ~iKill;
  assign ex_acc  = iExVld & oExRdy;
  assign link_wr = iJump & (iRdIdx != 5'd0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    redir_pc_d = redir_pc_q;
    wb_vld_d   = 1'b0;
    wb_idx_d   = wb_idx_q;
    wb_data_d  = wb_data_q;
    exc_vld_d  = 1'b0;
    exc_tval_d = exc_tval_q;

    if (iKill) begin
      // Kill from commit wins over everything, including a same-cycle handshake
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ex_acc) begin
            if (chk_misalign) begin
              exc_vld_d  = 1'b1;
              exc_tval_d = iTgtAddr;
            end else begin
              if (link_wr) begin
                wb_vld_d  = 1'b1;
                wb_idx_d  = iRdIdx;
                wb_data_d = iLinkPc;
              end
              if (chk_mispred) begin
                redir_pc_d = chk_target;
                state_d    = REDIR;
              end
            end
          end
        end
        REDIR: begin
          if (iRedirRdy) begin
            if (FLUSH_CYC == 0) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              state_d = FLUSH;
              cnt_d   = FLUSH_INIT;
            end
          end
        end
        FLUSH: begin
          if (cnt_q <= 4'd1) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      redir_pc_q <= '0;
      wb_vld_q   <= 1'b0;
      wb_idx_q   <= '0;
      wb_data_q  <= '0;
      exc_vld_q  <= 1'b0;
      exc_tval_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      redir_pc_q <= redir_pc_d;
      wb_vld_q   <= wb_vld_d;
      wb_idx_q   <= wb_idx_d;
      wb_data_q  <= wb_data_d;
      exc_vld_q  <= exc_vld_d;
      exc_tval_q <= exc_tval_d;
    end
  end

  assign oRedirVld = (state_q == REDIR);
  assign oRedirPc  = redir_pc_q;
  // Misaligned exception squashes younger work for its single pulse cycle
  assign oFlush    = (state_q != IDLE) | exc_vld_q;
  assign oWbVld    = wb_vld_q;
  assign oWbIdx    = wb_idx_q;
  assign oWbData   = wb_data_q;
  assign oExcVld   = exc_vld_q;
  assign oExcTval  = exc_tval_q;

endmodule

// File: tb/tb_zion_riscv_bj_redirect.sv
// Self-checking bench: directed scenarios plus random traffic, checked every
// cycle against a behavioural model of redirect/flush/writeback/exception.
module tb_zion_riscv_bj_redirect;

  localparam int FLUSH_N = 2;

  logic        iClk = 1'b0;
  logic        iRst_n = 1'b0;
  logic        iExVld = 1'b0;
  logic        oExRdy;
  logic [1:0]  iBjEn = 2'b00;
  logic        iJump = 1'b0;
  logic [31:0] iTgtAddr = '0;
  logic [31:0] iLinkPc = '0;
  logic [4:0]  iRdIdx = '0;
  logic        iPredTaken = 1'b0;
  logic [31:0] iPredTgt = '0;
  logic        iKill = 1'b0;
  logic        oRedirVld;
  logic        iRedirRdy = 1'b0;
  logic [31:0] oRedirPc;
  logic        oFlush;
  logic        oWbVld;
  logic [4:0]  oWbIdx;
  logic [31:0] oWbData;
  logic        oExcVld;
  logic [31:0] oExcTval;

  zion_riscv_bj_redirect #(.RV64(0), .RVC(0), .FLUSH_CYC(FLUSH_N)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iExVld(iExVld), .oExRdy(oExRdy),
    .iBjEn(iBjEn), .iJump(iJump), .iTgtAddr(iTgtAddr), .iLinkPc(iLinkPc),
    .iRdIdx(iRdIdx), .iPredTaken(iPredTaken), .iPredTgt(iPredTgt),
    .iKill(iKill), .oRedirVld(oRedirVld), .iRedirRdy(iRedirRdy),
    .oRedirPc(oRedirPc), .oFlush(oFlush), .oWbVld(oWbVld), .oWbIdx(oWbIdx),
    .oWbData(oWbData), .oExcVld(oExcVld), .oExcTval(oExcTval)
  );

  always #5 iClk = ~iClk;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: a pending redirect, a count of remaining flush cycles,
  // and last-cycle pulses.
  bit        m_pend;
  bit [31:0] m_rpc;
  int        m_fl;
  bit        m_wb;
  bit [4:0]  m_widx;
  bit [31:0] m_wdata;
  bit        m_exc;
  bit [31:0] m_tval;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_rpc = '0; m_fl = 0; m_wb = 0; m_widx = '0;
    m_wdata = '0; m_exc = 0; m_tval = '0;
  endtask

  function automatic bit model_idle();
    return !m_pend && (m_fl == 0);
  endfunction

  task automatic model_step();
    bit taken, mis, mp;
    if (iKill) begin
      m_pend = 0; m_fl = 0; m_wb = 0; m_exc = 0;
    end else begin
      m_wb = 0; m_exc = 0;
      if (model_idle()) begin
        if (iExVld) begin
          taken = (iBjEn != 2'b00);
          mis   = taken && ((iTgtAddr % 4) != 0);
          if (mis) begin
            m_exc = 1; m_tval = iTgtAddr;
          end else begin
            if (iJump && iRdIdx != 0) begin
              m_wb = 1; m_widx = iRdIdx; m_wdata = iLinkPc;
            end
            mp = (taken != iPredTaken) || (taken && iTgtAddr != iPredTgt);
            if (mp) begin
              m_pend = 1; m_rpc = taken ? iTgtAddr : iLinkPc;
            end
          end
        end
      end else if (m_pend) begin
        if (iRedirRdy) begin
          m_pend = 0; m_fl = FLUSH_N;
        end
      end else begin
        m_fl = m_fl - 1;
      end
    end
  endtask

  task automatic compare_outputs();
    chk("redir_vld", 32'(oRedirVld), 32'(m_pend));
    if (m_pend) chk("redir_pc", oRedirPc, m_rpc);
    chk("flush", 32'(oFlush), 32'(m_pend || m_fl > 0 || m_exc));
    chk("wb_vld", 32'(oWbVld), 32'(m_wb));
    if (m_wb) begin
      chk("wb_idx", 32'(oWbIdx), 32'(m_widx));
      chk("wb_data", oWbData, m_wdata);
    end
    chk("exc_vld", 32'(oExcVld), 32'(m_exc));
    if (m_exc) chk("exc_tval", oExcTval, m_tval);
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic cycle();
    #1;
    chk("ex_rdy", 32'(oExRdy), 32'(model_idle() && !iKill));
    @(posedge iClk);
    model_step();
    #1;
    compare_outputs();
    @(negedge iClk);
  endtask

  task automatic ex(input logic [1:0] bj, input logic jmp, input logic [31:0] tgt,
                    input logic [31:0] link, input logic [4:0] rd,
                    input logic pt, input logic [31:0] ptgt);
    iExVld = 1'b1; iBjEn = bj; iJump = jmp; iTgtAddr = tgt; iLinkPc = link;
    iRdIdx = rd; iPredTaken = pt; iPredTgt = ptgt;
  endtask

  task automatic idle_in();
    iExVld = 1'b0; iBjEn = 2'b00; iJump = 1'b0; iKill = 1'b0; iRedirRdy = 1'b0;
  endtask

  initial begin
    model_reset();
    #1;
    chk("rst_redir_vld", 32'(oRedirVld), 32'd0);
    chk("rst_flush", 32'(oFlush), 32'd0);
    chk("rst_wb_vld", 32'(oWbVld), 32'd0);
    chk("rst_exc_vld", 32'(oExcVld), 32'd0);
    chk("rst_redir_pc", oRedirPc, 32'd0);
    chk("rst_wb_data", oWbData, 32'd0);
    chk("rst_wb_idx", 32'(oWbIdx), 32'd0);
    chk("rst_exc_tval", oExcTval, 32'd0);
    @(negedge iClk);
    @(negedge iClk);
    iRst_n = 1'b1;

    // Correct not-taken
    ex(2'b00, 1'b0, 32'h80, 32'h1004, 5'd0, 1'b0, 32'h0);
    cycle();
    chk("nt_redir", 32'(oRedirVld), 32'd0);
    chk("nt_flush", 32'(oFlush), 32'd0);
    chk("nt_rdy", 32'(oExRdy), 32'd1);

    // Mispredict taken, fetch stalls 3 cycles
    ex(2'b10, 1'b0, 32'h100, 32'h1004, 5'd0, 1'b0, 32'h0);
    cycle();
    chk("mp_redir_vld", 32'(oRedirVld), 32'd1);
    chk("mp_redir_pc", oRedirPc, 32'h100);
    ex(2'b01, 1'b1, 32'h500, 32'h600, 5'd7, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("mp_hold_pc", oRedirPc, 32'h100);
      chk("mp_hold_rdy", 32'(oExRdy), 32'd0);
    end
    idle_in();
    iRedirRdy = 1'b1;
    cycle();
    iRedirRdy = 1'b0;
    chk("mp_post_vld", 32'(oRedirVld), 32'd0);
    chk("mp_flush1", 32'(oFlush), 32'd1);
    cycle();
    chk("mp_flush2", 32'(oFlush), 32'd1);
    cycle();
    chk("mp_flush_end", 32'(oFlush), 32'd0);
    chk("mp_idle_rdy", 32'(oExRdy), 32'd1);

    // JAL correctly predicted, rd=1 then rd=0
    ex(2'b01, 1'b1, 32'h300, 32'h2004, 5'd1, 1'b1, 32'h300);
    cycle();
    chk("jal_wb_vld", 32'(oWbVld), 32'd1);
    chk("jal_wb_idx", 32'(oWbIdx), 32'd1);
    chk("jal_wb_data", oWbData, 32'h2004);
    chk("jal_redir", 32'(oRedirVld), 32'd0);
    ex(2'b01, 1'b1, 32'h300, 32'h2008, 5'd0, 1'b1, 32'h300);
    cycle();
    chk("jal_rd0_wb", 32'(oWbVld), 32'd0);

    // Misaligned target
    ex(2'b01, 1'b1, 32'h102, 32'h3004, 5'd3, 1'b1, 32'h102);
    cycle();
    chk("mis_exc", 32'(oExcVld), 32'd1);
    chk("mis_tval", oExcTval, 32'h102);
    chk("mis_flush", 32'(oFlush), 32'd1);
    chk("mis_wb", 32'(oWbVld), 32'd0);
    chk("mis_redir", 32'(oRedirVld), 32'd0);
    idle_in();
    cycle();
    chk("mis_flush_end", 32'(oFlush), 32'd0);

    // Wrong target, then kill with handshake in REDIR
    ex(2'b11, 1'b0, 32'h40, 32'h4004, 5'd0, 1'b1, 32'h44);
    cycle();
    chk("wt_redir_pc", oRedirPc, 32'h40);
    idle_in();
    iKill = 1'b1; iRedirRdy = 1'b1;
    cycle();
    idle_in();
    chk("kill_redir_vld", 32'(oRedirVld), 32'd0);
    chk("kill_redir_flush", 32'(oFlush), 32'd0);

    // Kill during FLUSH
    ex(2'b00, 1'b1, 32'h0, 32'h5004, 5'd2, 1'b1, 32'h77);
    cycle();
    idle_in();
    iRedirRdy = 1'b1;
    cycle();
    idle_in();
    iKill = 1'b1;
    cycle();
    idle_in();
    chk("kill_flush", 32'(oFlush), 32'd0);

    // Async reset mid-REDIR
    ex(2'b10, 1'b0, 32'h900, 32'h6004, 5'd4, 1'b0, 32'h0);
    cycle();
    idle_in();
    #2;
    iRst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_redir_vld", 32'(oRedirVld), 32'd0);
    chk("arst_flush", 32'(oFlush), 32'd0);
    chk("arst_wb_vld", 32'(oWbVld), 32'd0);
    chk("arst_redir_pc", oRedirPc, 32'd0);
    chk("arst_wb_data", oWbData, 32'd0);
    chk("arst_rdy", 32'(oExRdy), 32'd1);
    @(negedge iClk);
    iRst_n = 1'b1;

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      iExVld     = ($urandom_range(0, 9) < 7);
      iBjEn      = 2'($urandom_range(0, 3));
      iJump      = 1'($urandom_range(0, 1));
      iTgtAddr   = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 9) == 0) iTgtAddr[1:0] = 2'($urandom_range(1, 3));
      iPredTgt   = ($urandom_range(0, 2) != 0) ? iTgtAddr : {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      iLinkPc    = $urandom;
      iRdIdx     = 5'($urandom_range(0, 3));
      iPredTaken = 1'($urandom_range(0, 1));
      iKill      = ($urandom_range(0, 19) == 0);
      iRedirRdy  = ($urandom_range(0, 9) < 4);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
